// File: rtl/bcd_to_bin_pkg.sv
// Shared constants and state encoding for the two-digit BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned BCD_DIGITS  = 2;
    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned BCD_W       = BCD_DIGITS * DIGIT_W;
    localparam int unsigned BIN_W       = 8;
    localparam int unsigned SHIFT_COUNT = 8;

    localparam logic [DIGIT_W-1:0] CORR_THRESH = 4'd8;
    localparam logic [DIGIT_W-1:0] CORR_SUB    = 4'd3;
    localparam logic [DIGIT_W-1:0] BCD_MAX     = 4'd9;

endpackage

// File: rtl/bcd_to_bin_if.sv
// Request/result handshake between the digit entry logic and the converter.
interface bcd_to_bin_if;
    import bcd_pkg::*;

    logic               start;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
    logic               ready;
    logic               done;
    logic               err;
    logic [BIN_W-1:0]   binary;

    modport master (
        output start, tens, ones,
        input  ready, done, err, binary
    );

    modport slave (
        input  start, tens, ones,
        output ready, done, err, binary
    );

endinterface

// File: rtl/bcd_digit_corr.sv
// Reverse double dabble digit correction: subtract 3 when the digit is 8 or more.
module bcd_digit_corr
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] corr
);

    always_comb begin
        corr = digit;
        if (digit >= CORR_THRESH) begin
            corr = digit - CORR_SUB;
        end
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential two-digit BCD-to-binary converter (reverse double dabble, 8 shift cycles).
module bcd_to_bin
    import bcd_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    bcd_to_bin_if.slave  bus
);

    localparam logic [3:0] LAST_ITER = 4'(SHIFT_COUNT - 1);

    state_t             state;
    logic [BCD_W-1:0]   bcd;
    logic [BIN_W-1:0]   shr;
    logic [3:0]         cnt;
    logic [15:0]        shifted;
    logic [DIGIT_W-1:0] tens_corr;
    logic [DIGIT_W-1:0] ones_corr;

    // {bcd, shr} moved right as one word; the bcd LSB falls into the shr MSB
    assign shifted = {1'b0, bcd, shr[BIN_W-1:1]};

    bcd_digit_corr u_tens_corr (
        .digit (shifted[15:12]),
        .corr  (tens_corr)
    );

    bcd_digit_corr u_ones_corr (
        .digit (shifted[11:8]),
        .corr  (ones_corr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bus.ready  <= 1'b1;
            bus.done   <= 1'b0;
            bus.err    <= 1'b0;
            bus.binary <= '0;
            bcd        <= '0;
            shr        <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bcd       <= {bus.tens, bus.ones};
                        shr       <= '0;
                        cnt       <= '0;
                        bus.ready <= 1'b0;
                        if (bus.tens > BCD_MAX || bus.ones > BCD_MAX) begin
                            state      <= DONE;
                            bus.binary <= '0;
                            bus.err    <= 1'b1;
                            bus.done   <= 1'b1;
                        end else begin
                            state   <= SHIFT;
                            bus.err <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    bcd <= {tens_corr, ones_corr};
                    shr <= shifted[BIN_W-1:0];
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_ITER) begin
                        bus.binary <= shifted[BIN_W-1:0];
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    bus.done  <= 1'b0;
                    bus.ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A legal conversion always drains the BCD register and yields a value below 128
    assert property (@(posedge clk) disable iff (rst)
        (state == DONE && !bus.err) |-> (bcd == '0 && !bus.binary[BIN_W-1]));

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: accepts are predicted at the negedge, results checked on done.
module tb_bcd_to_bin;
    import bcd_pkg::*;

    typedef struct {
        logic [7:0]  bin;
        logic        err;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    exp_t        sb[$];

    logic        prev_done = 1'b0;
    logic        prev_rst  = 1'b1;
    logic        prev_acc  = 1'b0;
    logic [7:0]  prev_bin  = '0;
    logic        prev_err  = 1'b0;

    bcd_to_bin_if bus ();

    bcd_to_bin dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output checking and accept prediction, both away from the active edge
    always @(negedge clk) begin
        automatic logic acc = 1'b0;
        automatic exp_t e;
        if (bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'd0, bus.done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("binary", {24'd0, bus.binary}, {24'd0, e.bin});
                chk("err", {31'd0, bus.err}, {31'd0, e.err});
                chk("latency", cyc, e.due);
                if (!bus.err) chk("bcd_cleared", {24'd0, dut.bcd}, 32'd0);
            end
            chk("done_one_cycle", {31'd0, prev_done}, 32'd0);
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            chk("done_timeout", cyc, sb[0].due);
            void'(sb.pop_front());
        end
        if (prev_done && !bus.done) chk("ready_after_done", {31'd0, bus.ready}, 32'd1);
        if (!prev_rst && !prev_acc && !bus.done) begin
            chk("binary_stable", {24'd0, bus.binary}, {24'd0, prev_bin});
            chk("err_stable", {31'd0, bus.err}, {31'd0, prev_err});
        end
        if (rst) begin
            sb.delete();
        end else if (bus.ready && bus.start) begin
            acc   = 1'b1;
            e.err = (bus.tens > 4'd9) || (bus.ones > 4'd9);
            e.bin = e.err ? 8'd0 : 8'(bus.tens * 10 + bus.ones);
            e.due = e.err ? cyc + 1 : cyc + 9;
            sb.push_back(e);
        end
        prev_done <= bus.done;
        prev_rst  <= rst;
        prev_acc  <= acc;
        prev_bin  <= bus.binary;
        prev_err  <= bus.err;
    end

    task automatic wait_ready();
        int unsigned n = 0;
        while (!bus.ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.ready) chk("ready_timeout", {31'd0, bus.ready}, 32'd1);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic conv(input logic [3:0] t, input logic [3:0] o);
        wait_ready();
        bus.tens  = t;
        bus.ones  = o;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("ready_drop", {31'd0, bus.ready}, 32'd0);
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.tens  = '0;
        bus.ones  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_binary", {24'd0, bus.binary}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        conv(4'd9, 4'd9);
        conv(4'd4, 4'd2);
        conv(4'd0, 4'd0);
        conv(4'hA, 4'd3);
        conv(4'd1, 4'd5);

        // start held high while the digits keep moving
        bus.start = 1'b1;
        for (int i = 0; i < 45; i++) begin
            bus.tens = 4'($urandom_range(0, 9));
            bus.ones = 4'($urandom_range(0, 9));
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        drain();

        conv(4'd9, 4'd8);
        wait_ready();
        bus.tens  = 4'd5;
        bus.ones  = 4'd5;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {31'd0, bus.ready}, 32'd1);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_binary", {24'd0, bus.binary}, 32'd0);
        @(posedge clk); #1;
        conv(4'd5, 4'd7);

        for (int i = 0; i < 100; i++) begin
            conv(4'(i / 10), 4'(i % 10));
        end
        conv(4'd3, 4'hF);
        conv(4'hF, 4'hF);
        conv(4'd9, 4'hA);
        conv(4'd8, 4'd1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (vectors %0d, miscompares %0d)", n_vec, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
